// File: rtl/forwarding_hazard_unit_pkg.sv
// Shared constants and types for the forwarding / hazard unit and its
// multiply tracker.
package forwarding_hazard_unit_pkg;

  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b01;
  localparam logic [1:0] FWD_MEMWB = 2'b10;

  // Wide enough for the largest legal multiplier latency (7).
  localparam int CNT_W = 3;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mult_state_e;

endpackage

// File: rtl/forwarding_hazard_unit_mult_tracker.sv
// Tracks one in-flight multiply: down-counts its latency and remembers its
// destination register so the hazard logic can stall dependent instructions.
//
// state | meaning
// IDLE  | no multiply in flight, cnt is 0
// BUSY  | multiply in flight, cnt counts remaining cycles down to 0
module mult_tracker
  import forwarding_hazard_unit_pkg::*;
#(
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned MULT_LAT   = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  accept_i,
  input  logic [REG_ADDR_W-1:0] rd_i,
  output logic                  busy_o,
  output logic                  wb_valid_o,
  output logic [REG_ADDR_W-1:0] wb_rd_o
);

  mult_state_e           state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [REG_ADDR_W-1:0] rd_q, rd_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rd_d    = rd_q;
    if (accept_i) begin
      state_d = BUSY;
      cnt_d   = CNT_W'(MULT_LAT);
      rd_d    = rd_i;
    end else if (state_q == BUSY) begin
      if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
      // Destination stays visible after completion until the next accept.
      if (cnt_q <= CNT_W'(1)) state_d = IDLE;
    end
  end

  assign busy_o     = (cnt_q != '0);
  assign wb_valid_o = (cnt_q == CNT_W'(1));
  assign wb_rd_o    = rd_q;

endmodule

// File: rtl/forwarding_hazard_unit.sv
// Operand forwarding selects, load-use detection and multiply hazard stalls
// for a classic five-stage pipeline.
module forwarding_hazard_unit
  import forwarding_hazard_unit_pkg::*;
#(
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned MULT_LAT   = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_is_mult,
  input  logic [REG_ADDR_W-1:0] ex_rs1,
  input  logic [REG_ADDR_W-1:0] ex_rs2,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_mem_read,
  input  logic [REG_ADDR_W-1:0] mem_rd,
  input  logic                  mem_reg_write,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  input  logic                  wb_reg_write,
  output logic [1:0]            fwd_a_sel,
  output logic [1:0]            fwd_b_sel,
  output logic                  stall,
  output logic                  mult_busy,
  output logic                  mult_wb_valid,
  output logic [REG_ADDR_W-1:0] mult_wb_rd
);

  function automatic logic [1:0] fwd_sel(input logic [REG_ADDR_W-1:0] rs);
    // The younger EX/MEM result wins over MEM/WB.
    if (mem_reg_write && (mem_rd != '0) && (mem_rd == rs)) return FWD_EXMEM;
    if (wb_reg_write && (wb_rd != '0) && (wb_rd == rs))    return FWD_MEMWB;
    return FWD_RF;
  endfunction

  logic load_use;
  logic mult_data_hit;
  logic mult_stall;
  logic mult_accept;

  assign fwd_a_sel = fwd_sel(ex_rs1);
  assign fwd_b_sel = fwd_sel(ex_rs2);

  assign load_use = ex_mem_read && (ex_rd != '0)
                    && ((ex_rd == id_rs1) || (ex_rd == id_rs2));

  assign mult_data_hit = (mult_wb_rd != '0)
                         && ((mult_wb_rd == id_rs1) || (mult_wb_rd == id_rs2));
  assign mult_stall    = mult_busy && (id_is_mult || mult_data_hit);

  assign stall       = load_use || mult_stall;
  assign mult_accept = id_is_mult && !stall;

  mult_tracker #(
    .REG_ADDR_W(REG_ADDR_W),
    .MULT_LAT  (MULT_LAT)
  ) u_mult_tracker (
    .clk       (clk),
    .rst       (rst),
    .accept_i  (mult_accept),
    .rd_i      (id_rd),
    .busy_o    (mult_busy),
    .wb_valid_o(mult_wb_valid),
    .wb_rd_o   (mult_wb_rd)
  );

endmodule

// File: tb/tb_forwarding_hazard_unit.sv
// Directed bench for forwarding_hazard_unit with a cycle-timestamp model of
// the multiply pipeline checked every cycle, plus literal expectations.
module tb_forwarding_hazard_unit;

  localparam int W   = 5;
  localparam int LAT = 3;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] id_rs1, id_rs2, id_rd, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
  logic         id_is_mult, ex_mem_read, mem_reg_write, wb_reg_write;
  logic [1:0]   fwd_a_sel, fwd_b_sel;
  logic         stall, mult_busy, mult_wb_valid;
  logic [W-1:0] mult_wb_rd;

  always #5 clk = ~clk;

  forwarding_hazard_unit #(.REG_ADDR_W(W), .MULT_LAT(LAT)) dut (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_is_mult(id_is_mult),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
    .mem_rd(mem_rd), .mem_reg_write(mem_reg_write),
    .wb_rd(wb_rd), .wb_reg_write(wb_reg_write),
    .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel), .stall(stall),
    .mult_busy(mult_busy), .mult_wb_valid(mult_wb_valid), .mult_wb_rd(mult_wb_rd)
  );

  int total = 0;
  int bad   = 0;
  bit chk_en = 0;

  // Model: edge count, edge at which the last multiply was accepted.
  int           edge_n = 0;
  int           acc_edge = 0;
  bit           m_active = 0;
  logic [W-1:0] m_rd = '0;

  function automatic logic [1:0] exp_fwd(input logic [W-1:0] rs);
    if (mem_reg_write && mem_rd != 0 && mem_rd == rs) return 2'b01;
    if (wb_reg_write && wb_rd != 0 && wb_rd == rs) return 2'b10;
    return 2'b00;
  endfunction

  function automatic bit m_busy();
    return m_active && (edge_n - acc_edge) < LAT;
  endfunction

  function automatic bit m_valid();
    return m_active && (edge_n - acc_edge) == LAT - 1;
  endfunction

  function automatic bit m_stall();
    bit lu, ms;
    lu = ex_mem_read && ex_rd != 0 && (ex_rd == id_rs1 || ex_rd == id_rs2);
    ms = m_busy() && (id_is_mult || (m_rd != 0 && (m_rd == id_rs1 || m_rd == id_rs2)));
    return lu || ms;
  endfunction

  always @(posedge clk) begin
    bit s;
    s = m_stall();
    edge_n++;
    if (rst) begin
      m_active = 0;
      m_rd = '0;
    end else if (id_is_mult && !s) begin
      m_active = 1;
      acc_edge = edge_n;
      m_rd = id_rd;
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s at t=%0t: got=%0h expected=%0h", name, $time, got, exp);
    end
  endtask

  task automatic compare_all();
    chk("model.fwd_a", 32'(fwd_a_sel), 32'(exp_fwd(ex_rs1)));
    chk("model.fwd_b", 32'(fwd_b_sel), 32'(exp_fwd(ex_rs2)));
    chk("model.stall", 32'(stall), 32'(m_stall()));
    chk("model.busy", 32'(mult_busy), 32'(m_busy()));
    chk("model.wb_valid", 32'(mult_wb_valid), 32'(m_valid()));
    chk("model.wb_rd", 32'(mult_wb_rd), 32'(m_rd));
  endtask

  // Compare at the falling edge, then advance to just after the next rising edge.
  task automatic cycle();
    @(negedge clk);
    #1;
    if (chk_en) compare_all();
    @(posedge clk);
    #2;
  endtask

  task automatic clr();
    id_rs1 = '0; id_rs2 = '0; id_rd = '0; id_is_mult = 0;
    ex_rs1 = '0; ex_rs2 = '0; ex_rd = '0; ex_mem_read = 0;
    mem_rd = '0; mem_reg_write = 0; wb_rd = '0; wb_reg_write = 0;
  endtask

  task automatic lit_mult(input string tag, input bit b, input bit v, input bit s);
    chk({tag, ".busy"}, 32'(mult_busy), 32'(b));
    chk({tag, ".wb_valid"}, 32'(mult_wb_valid), 32'(v));
    chk({tag, ".stall"}, 32'(stall), 32'(s));
  endtask

  initial begin
    clr();
    rst = 1;
    @(posedge clk); #2;
    cycle();
    chk_en = 1;

    // Reset state and forwarding still live while reset is held.
    ex_rs1 = 5; mem_rd = 5; mem_reg_write = 1;
    #1;
    lit_mult("reset", 0, 0, 0);
    chk("reset.wb_rd", 32'(mult_wb_rd), 32'd0);
    chk("reset.fwd_a", 32'(fwd_a_sel), 32'h1);
    cycle();
    rst = 0;

    // EX/MEM beats MEM/WB; dropping the EX/MEM write falls back to MEM/WB.
    clr(); ex_rs1 = 5; ex_rs2 = 5; mem_rd = 5; mem_reg_write = 1; wb_rd = 5; wb_reg_write = 1;
    #1;
    chk("prio.fwd_a", 32'(fwd_a_sel), 32'h1);
    chk("prio.fwd_b", 32'(fwd_b_sel), 32'h1);
    cycle();
    mem_reg_write = 0;
    #1;
    chk("memwb.fwd_a", 32'(fwd_a_sel), 32'h2);
    cycle();

    // Register 0 never forwards; a zero EX/MEM match does not mask MEM/WB.
    clr(); ex_rs2 = 0; mem_rd = 0; mem_reg_write = 1;
    #1;
    chk("r0.fwd_b", 32'(fwd_b_sel), 32'h0);
    chk("r0.stall", 32'(stall), 32'h0);
    cycle();
    clr(); ex_rs1 = 0; mem_rd = 0; mem_reg_write = 1; wb_rd = 0; wb_reg_write = 1;
    ex_rs2 = 6; wb_rd = 6;
    #1;
    chk("r0b.fwd_a", 32'(fwd_a_sel), 32'h0);
    chk("wbonly.fwd_b", 32'(fwd_b_sel), 32'h2);
    cycle();

    // Load-use.
    clr(); ex_mem_read = 1; ex_rd = 7; id_rs2 = 7;
    #1;
    chk("loaduse.hit", 32'(stall), 32'h1);
    cycle();
    id_rs2 = 8;
    #1;
    chk("loaduse.miss", 32'(stall), 32'h0);
    cycle();
    ex_rd = 0; id_rs1 = 0;
    #1;
    chk("loaduse.r0", 32'(stall), 32'h0);
    cycle();

    // Multiply to r9 with a dependent instruction waiting in ID.
    clr(); id_is_mult = 1; id_rd = 9; id_rs1 = 9;
    #1;
    chk("mul9.accept_stall", 32'(stall), 32'h0);
    cycle();
    id_is_mult = 0;
    #1; lit_mult("mul9.t1", 1, 0, 1); chk("mul9.rd", 32'(mult_wb_rd), 32'd9);
    cycle();
    #1; lit_mult("mul9.t2", 1, 0, 1);
    cycle();
    #1; lit_mult("mul9.t3", 1, 1, 1);
    cycle();
    #1; lit_mult("mul9.t4", 0, 0, 0); chk("mul9.rd_hold", 32'(mult_wb_rd), 32'd9);
    cycle();

    // Multiply to r0: tracked but never a data stall.
    clr(); id_is_mult = 1; id_rd = 0;
    cycle();
    id_is_mult = 0;
    #1; lit_mult("mul0.t1", 1, 0, 0);
    cycle();
    cycle();
    #1; lit_mult("mul0.t3", 1, 1, 0);
    cycle();

    // Back-to-back multiplies: second waits out the first, then reset aborts it.
    clr(); id_is_mult = 1; id_rd = 10;
    cycle();
    id_rd = 11;
    #1; lit_mult("b2b.t1", 1, 0, 1);
    cycle();
    #1; lit_mult("b2b.t2", 1, 0, 1);
    cycle();
    #1; lit_mult("b2b.t3", 1, 1, 1);
    cycle();
    #1; lit_mult("b2b.t4", 0, 0, 0);
    cycle();
    id_is_mult = 0; rst = 1;
    #1; lit_mult("b2b.acc", 1, 0, 0); chk("b2b.rd", 32'(mult_wb_rd), 32'd11);
    cycle();
    rst = 0;
    for (int i = 0; i < 4; i++) begin
      #1; lit_mult("abort", 0, 0, 0);
      chk("abort.rd", 32'(mult_wb_rd), 32'd0);
      cycle();
    end

    // Short sweep over a small register range; model checks every cycle.
    for (int i = 0; i < 60; i++) begin
      id_rs1 = W'($urandom_range(0, 3)); id_rs2 = W'($urandom_range(0, 3));
      id_rd = W'($urandom_range(0, 3));  id_is_mult = ($urandom_range(0, 3) == 0);
      ex_rs1 = W'($urandom_range(0, 3)); ex_rs2 = W'($urandom_range(0, 3));
      ex_rd = W'($urandom_range(0, 3));  ex_mem_read = $urandom_range(0, 1) == 1;
      mem_rd = W'($urandom_range(0, 3)); mem_reg_write = $urandom_range(0, 1) == 1;
      wb_rd = W'($urandom_range(0, 3));  wb_reg_write = $urandom_range(0, 1) == 1;
      rst = ($urandom_range(0, 29) == 0);
      cycle();
    end
    rst = 0;
    clr();
    cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
